// File: rtl/uart_pkg.sv
// Shared UART types: TX/RX frame state enums, parity constants and parity helper.
// No logic of its own; imported by the UART core.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic PARITY_EVEN   = 1'b0;
    localparam logic PARITY_ODD    = 1'b1;
    localparam int   MAX_DATA_BITS = 9;

    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a separate level counter; head visible combinationally.
// Push/pop take effect at the clock edge; push while full is dropped unless a pop accompanies it.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop);
    assign pop_data = mem[rd_ptr];

    // Storage is cleared on reset so the show-ahead head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_core_v2.sv
// Buffered full-duplex UART, runtime baud/parity/stop format latched per frame, sticky line errors.
// RX byte reaches the FIFO one clock after the stop sample; full TX FIFO drops writes, full RX FIFO sets overrun.
module uart_core_v2 #(
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int DIV_W     = 16,
    parameter int RESET_DIV = 216
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    output logic                        tx,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    input  logic                        two_stop,
    input  logic                        write,
    input  logic [DATA_BITS-1:0]        write_data,
    input  logic                        read,
    output logic [DATA_BITS-1:0]        read_data,
    output logic                        tx_fifo_empty,
    output logic                        tx_fifo_full,
    output logic                        rx_fifo_empty,
    output logic                        rx_fifo_full,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    input  logic [$clog2(RX_DEPTH):0]   rx_thresh,
    output logic                        rx_thresh_hit,
    output logic                        err_overrun,
    output logic                        err_frame,
    output logic                        err_parity,
    input  logic                        clear_errors
);
    import uart_pkg::*;

    localparam int RLW = $clog2(RX_DEPTH) + 1;
    localparam int BW  = $clog2(DATA_BITS);

    // ---------------- TX ----------------
    tx_state_t             tx_state, tx_state_n;
    logic [DIV_W-1:0]      tx_div, tx_cnt;
    logic [DATA_BITS-1:0]  tx_shreg, tx_head;
    logic [BW-1:0]         tx_bit_cnt;
    logic                  tx_par_en, tx_two_stop, tx_par_bit, tx_stop_cnt;
    logic                  tx_pop, tx_bit_end;

    assign tx_bit_end = (tx_cnt == tx_div);

    sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_BITS)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (write),
        .push_data (write_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .empty     (tx_fifo_empty),
        .full      (tx_fifo_full),
        .level     (tx_level)
    );

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        tx         = 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (tx_bit_end) tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                tx = tx_shreg[0];
                if (tx_bit_end && tx_bit_cnt == BW'(DATA_BITS - 1))
                    tx_state_n = tx_par_en ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx = tx_par_bit;
                if (tx_bit_end) tx_state_n = TX_STOP;
            end
            TX_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (tx_bit_end && (tx_stop_cnt || !tx_two_stop)) begin
                    if (!tx_fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state    <= TX_IDLE;
            tx_div      <= DIV_W'(RESET_DIV);
            tx_cnt      <= '0;
            tx_shreg    <= '0;
            tx_bit_cnt  <= '0;
            tx_par_en   <= 1'b0;
            tx_two_stop <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_stop_cnt <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_pop) begin
                tx_shreg    <= tx_head;
                tx_par_bit  <= parity_of(MAX_DATA_BITS'(tx_head), parity_odd == PARITY_ODD);
                tx_div      <= baud_div;
                tx_par_en   <= parity_en;
                tx_two_stop <= two_stop;
                tx_cnt      <= '0;
                tx_bit_cnt  <= '0;
                tx_stop_cnt <= 1'b0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_state == TX_DATA) begin
                        tx_shreg   <= tx_shreg >> 1;
                        tx_bit_cnt <= tx_bit_cnt + BW'(1);
                    end
                    if (tx_state == TX_STOP) tx_stop_cnt <= 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + DIV_W'(1);
                end
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_t             rx_state, rx_state_n;
    logic                  rx_sync1, rx_sync2, rx_prev;
    logic [DIV_W-1:0]      rx_div, rx_half, rx_cnt;
    logic [DIV_W:0]        div_plus1;
    logic [DATA_BITS-1:0]  rx_shreg;
    logic [BW-1:0]         rx_bit_cnt;
    logic                  rx_par_en, rx_par_odd, rx_push, rx_sample, rx_fall;
    logic                  rx_push_ok, rx_pop_ok, par_err_set, frame_err_set, overrun_set;
    logic [RLW-1:0]        rx_level_next;

    assign div_plus1 = {1'b0, baud_div} + (DIV_W + 1)'(1);
    assign rx_fall   = rx_prev && !rx_sync2;
    assign rx_sample = (rx_state == RX_START) ? (rx_cnt == rx_half) : (rx_cnt == rx_div);

    assign par_err_set   = (rx_state == RX_PARITY) && rx_sample &&
                           (rx_sync2 != parity_of(MAX_DATA_BITS'(rx_shreg), rx_par_odd != PARITY_EVEN));
    assign frame_err_set = (rx_state == RX_STOP) && rx_sample && !rx_sync2;
    assign overrun_set   = rx_push && rx_fifo_full && !read;

    assign rx_push_ok    = rx_push && (!rx_fifo_full || read);
    assign rx_pop_ok     = read && !rx_fifo_empty;
    assign rx_level_next = rx_level + RLW'(rx_push_ok) - RLW'(rx_pop_ok);

    sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_shreg),
        .pop       (read),
        .pop_data  (read_data),
        .empty     (rx_fifo_empty),
        .full      (rx_fifo_full),
        .level     (rx_level)
    );

    always_comb begin
        rx_state_n = rx_state;
        unique case (rx_state)
            RX_IDLE:   if (rx_fall) rx_state_n = RX_START;
            RX_START:  if (rx_sample) rx_state_n = rx_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit_cnt == BW'(DATA_BITS - 1))
                           rx_state_n = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_state_n = RX_STOP;
            RX_STOP:   if (rx_sample) rx_state_n = RX_IDLE;
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1      <= 1'b1;
            rx_sync2      <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_div        <= DIV_W'(RESET_DIV);
            rx_half       <= '0;
            rx_cnt        <= '0;
            rx_shreg      <= '0;
            rx_bit_cnt    <= '0;
            rx_par_en     <= 1'b0;
            rx_par_odd    <= 1'b0;
            rx_push       <= 1'b0;
            err_overrun   <= 1'b0;
            err_frame     <= 1'b0;
            err_parity    <= 1'b0;
            rx_thresh_hit <= 1'b0;
        end else begin
            rx_sync1 <= rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
            rx_state <= rx_state_n;
            rx_push  <= 1'b0;
            if (rx_state == RX_IDLE) begin
                // The edge-detect clock is the first clock of the start bit.
                if (rx_fall) begin
                    rx_cnt     <= DIV_W'(1);
                    rx_div     <= baud_div;
                    rx_half    <= div_plus1[DIV_W:1];
                    rx_par_en  <= parity_en;
                    rx_par_odd <= parity_odd;
                    rx_bit_cnt <= '0;
                end
            end else if (rx_sample) begin
                rx_cnt <= '0;
                if (rx_state == RX_DATA) begin
                    rx_shreg   <= {rx_sync2, rx_shreg[DATA_BITS-1:1]};
                    rx_bit_cnt <= rx_bit_cnt + BW'(1);
                end
                if (rx_state == RX_STOP) rx_push <= 1'b1;
            end else begin
                rx_cnt <= rx_cnt + DIV_W'(1);
            end
            err_parity    <= par_err_set   || (err_parity  && !clear_errors);
            err_frame     <= frame_err_set || (err_frame   && !clear_errors);
            err_overrun   <= overrun_set   || (err_overrun && !clear_errors);
            rx_thresh_hit <= (rx_level_next >= rx_thresh);
        end
    end

endmodule

// File: tb/tb_uart_core_v2.sv
// Directed bench for uart_core_v2 at baud_div=3 (4 clocks per bit): table-driven RX frames
// plus hand sequences for loopback, FIFO limits, TX parity, errors, overrun, reset and glitches.
module tb_uart_core_v2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        loop = 1'b0;
    logic        rx_drv = 1'b1;
    logic        rx_line;
    logic        tx;
    logic [15:0] baud_div = 16'd3;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        two_stop = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  write_data = 8'h00;
    logic        read = 1'b0;
    logic [7:0]  read_data;
    logic        tx_fifo_empty, tx_fifo_full, rx_fifo_empty, rx_fifo_full;
    logic [4:0]  tx_level, rx_level;
    logic [4:0]  rx_thresh = 5'd1;
    logic        rx_thresh_hit, err_overrun, err_frame, err_parity;
    logic        clear_errors = 1'b0;

    int checks = 0;
    int errors = 0;

    logic       mon_en = 1'b0;
    logic [7:0] mon_byte;
    logic [7:0] mon_q [$];

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       podd;
        logic       flip;
        logic       bad_stop;
        logic       exp_par;
        logic       exp_frame;
    } rx_vec_t;

    rx_vec_t vecs [6];

    always #5 clk = ~clk;
    assign rx_line = loop ? tx : rx_drv;

    uart_core_v2 #(
        .DATA_BITS(8), .TX_DEPTH(16), .RX_DEPTH(16), .DIV_W(16), .RESET_DIV(216)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx_line), .tx(tx),
        .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .write(write), .write_data(write_data), .read(read), .read_data(read_data),
        .tx_fifo_empty(tx_fifo_empty), .tx_fifo_full(tx_fifo_full),
        .rx_fifo_empty(rx_fifo_empty), .rx_fifo_full(rx_fifo_full),
        .tx_level(tx_level), .rx_level(rx_level), .rx_thresh(rx_thresh),
        .rx_thresh_hit(rx_thresh_hit), .err_overrun(err_overrun), .err_frame(err_frame),
        .err_parity(err_parity), .clear_errors(clear_errors)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-bangs one frame on rx at 4 clocks/bit, followed by one idle bit.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                              input logic flip, input logic bad_stop);
        rx_drv = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(4);
        end
        if (pen) begin
            rx_drv = (^d) ^ podd ^ flip;
            tick(4);
        end
        rx_drv = !bad_stop;
        tick(4);
        rx_drv = 1'b1;
        tick(4);
    endtask

    task automatic wait_tx_low(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check(name, ok, 1);
    endtask

    task automatic wait_rx_level(input logic [4:0] lvl, input string name);
        for (int i = 0; i < 400 && rx_level !== lvl; i++) tick(1);
        check(name, rx_level, lvl);
    endtask

    task automatic pulse_read();
        read = 1'b1;
        tick(1);
        read = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
    endtask

    // Independent 8N1 decoder on the tx pin, sampling each bit at its middle clock.
    always begin
        @(posedge clk);
        #1;
        if (mon_en && tx === 1'b0) begin
            tick(2);
            for (int i = 0; i < 8; i++) begin
                tick(4);
                mon_byte[i] = tx;
            end
            tick(4);
            mon_q.push_back(mon_byte);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_tx", tx, 1);
        check("rst_tx_empty", tx_fifo_empty, 1);
        check("rst_tx_full", tx_fifo_full, 0);
        check("rst_rx_empty", rx_fifo_empty, 1);
        check("rst_rx_full", rx_fifo_full, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_read_data", read_data, 0);
        check("rst_errors", {err_overrun, err_frame, err_parity}, 0);
        check("rst_thresh_hit", rx_thresh_hit, 0);

        // Loopback 8N1, two bytes back to back
        loop = 1'b1;
        write = 1'b1; write_data = 8'h55; tick(1);
        write_data = 8'hA3; tick(1);
        write = 1'b0;
        wait_rx_level(5'd2, "lb_rx_level");
        tick(1);
        check("lb_thresh_hit", rx_thresh_hit, 1);
        check("lb_byte0", read_data, 8'h55);
        pulse_read();
        check("lb_byte1", read_data, 8'hA3);
        pulse_read();
        check("lb_rx_empty", rx_fifo_empty, 1);
        check("lb_errors", {err_overrun, err_frame, err_parity}, 0);
        check("lb_tx_empty", tx_fifo_empty, 1);
        tick(20);
        loop = 1'b0;

        // Table-driven RX frames with parity / stop faults injected
        for (int v = 0; v < 6; v++) begin
            parity_en  = vecs[v].pen;
            parity_odd = vecs[v].podd;
            send_frame(vecs[v].data, vecs[v].pen, vecs[v].podd, vecs[v].flip, vecs[v].bad_stop);
            check($sformatf("vec%0d_level", v), rx_level, 1);
            check($sformatf("vec%0d_data", v), read_data, vecs[v].data);
            check($sformatf("vec%0d_err_parity", v), err_parity, vecs[v].exp_par);
            check($sformatf("vec%0d_err_frame", v), err_frame, vecs[v].exp_frame);
            pulse_read();
            pulse_clear();
        end
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // TX FIFO overfill during a busy frame
        mon_q.delete();
        mon_en = 1'b1;
        write = 1'b1; write_data = 8'h11; tick(1);
        write = 1'b0;
        tick(2);
        for (int i = 0; i < 17; i++) begin
            write = 1'b1;
            write_data = 8'(i);
            tick(1);
        end
        write = 1'b0;
        check("txf_full", tx_fifo_full, 1);
        check("txf_level", tx_level, 16);
        for (int i = 0; i < 1200 && mon_q.size() < 17; i++) tick(1);
        tick(60);
        check("txf_sent_count", mon_q.size(), 17);
        if (mon_q.size() == 17) begin
            check("txf_first", mon_q[0], 8'h11);
            for (int i = 0; i < 16; i++) check($sformatf("txf_byte%0d", i), mon_q[i+1], i);
        end
        check("txf_empty_after", tx_fifo_empty, 1);
        mon_en = 1'b0;

        // TX parity bit: odd parity of 0x07 is 0; format change mid-frame is ignored
        parity_en = 1'b1; parity_odd = 1'b1;
        write = 1'b1; write_data = 8'h07; tick(1);
        write = 1'b0;
        wait_tx_low("par_start");
        parity_en = 1'b0; parity_odd = 1'b0;
        tick(6);
        check("par_data_bit0", tx, 1);
        tick(32);
        check("par_bit", tx, 0);
        tick(4);
        check("par_stop", tx, 1);
        tick(10);

        // Frame error and clear
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fe_set", err_frame, 1);
        pulse_clear();
        check("fe_cleared", err_frame, 0);
        pulse_read();

        // Overrun with watermark 4
        rx_thresh = 5'd4;
        for (int f = 0; f < 17; f++) begin
            send_frame(8'h20 + 8'(f), 1'b0, 1'b0, 1'b0, 1'b0);
            if (f == 2) check("ovr_hit_at3", rx_thresh_hit, 0);
            if (f == 3) check("ovr_hit_at4", rx_thresh_hit, 1);
            if (f == 15) begin
                check("ovr_full_16", rx_fifo_full, 1);
                check("ovr_none_yet", err_overrun, 0);
            end
        end
        check("ovr_flag", err_overrun, 1);
        check("ovr_level", rx_level, 16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("ovr_byte%0d", k), read_data, 8'h20 + 8'(k));
            pulse_read();
        end
        pulse_read();
        check("ovr_drained_level", rx_level, 0);
        check("ovr_drained_empty", rx_fifo_empty, 1);
        rx_thresh = 5'd1;

        // Reset during a TX data bit
        write = 1'b1; write_data = 8'h00; tick(1);
        write_data = 8'h5A; tick(1);
        write = 1'b0;
        wait_tx_low("rst_mid_start");
        tick(10);
        check("rst_mid_pre_tx", tx, 0);
        check("rst_mid_pre_level", tx_level, 1);
        reset = 1'b1;
        tick(1);
        check("rst_mid_tx", tx, 1);
        check("rst_mid_tx_level", tx_level, 0);
        check("rst_mid_overrun", err_overrun, 0);
        reset = 1'b0;
        tick(100);
        check("rst_mid_tx_idle", tx, 1);

        // One-clock low glitch on rx is a false start
        rx_drv = 1'b0;
        tick(1);
        rx_drv = 1'b1;
        tick(60);
        check("glitch_level", rx_level, 0);
        check("glitch_empty", rx_fifo_empty, 1);
        check("glitch_errors", {err_frame, err_parity}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
